// File: rtl/estagio_id_ex_if.sv
// ID/EX stage bus: decode-side handshake and fields, MEM/WB forwarding taps,
// and the registered operands that feed the ALU.
interface estagio_id_ex_if;
  logic        in_valid;
  logic        in_ready;
  logic        ex_ready;
  logic        flush;

  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic        ALUSrc;
  logic        RegDst;
  logic [31:0] leituraA;
  logic [31:0] leituraB;
  logic [15:0] imediato;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic        fw_mem_valid;
  logic [4:0]  fw_mem_reg;
  logic [31:0] fw_mem_dado;
  logic        fw_wb_valid;
  logic [4:0]  fw_wb_reg;
  logic [31:0] fw_wb_dado;

  logic        out_valid;
  logic [3:0]  ALUcontrol;
  logic [31:0] entradaA;
  logic [31:0] entradaB;
  logic [4:0]  regDestino;
  logic        erro_funct;

  modport master (
    output in_valid, ex_ready, flush,
    output ALUOp, funct, ALUSrc, RegDst,
    output leituraA, leituraB, imediato, rs, rt, rd,
    output fw_mem_valid, fw_mem_reg, fw_mem_dado,
    output fw_wb_valid, fw_wb_reg, fw_wb_dado,
    input  in_ready, out_valid, ALUcontrol, entradaA, entradaB,
    input  regDestino, erro_funct
  );

  modport slave (
    input  in_valid, ex_ready, flush,
    input  ALUOp, funct, ALUSrc, RegDst,
    input  leituraA, leituraB, imediato, rs, rt, rd,
    input  fw_mem_valid, fw_mem_reg, fw_mem_dado,
    input  fw_wb_valid, fw_wb_reg, fw_wb_dado,
    output in_ready, out_valid, ALUcontrol, entradaA, entradaB,
    output regDestino, erro_funct
  );
endinterface

// File: rtl/estagio_id_ex.sv
// ID/EX one-entry pipeline register: decodes ALU control, builds ALU operands.
// Define FORWARDING_EN to take operands from the MEM/WB forwarding taps.
module estagio_id_ex (
  input logic            clk,
  input logic            rst_n,
  estagio_id_ex_if.slave bus
);

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  alu_control_q, alu_control_d;
  logic [31:0] entrada_a_q, entrada_a_d;
  logic [31:0] entrada_b_q, entrada_b_d;
  logic [4:0]  reg_destino_q, reg_destino_d;
  logic        erro_funct_q, erro_funct_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic        b_reg_q, b_reg_d;

  logic        out_valid;
  logic        in_ready;
  logic        load;
  logic [3:0]  alu_dec;
  logic        funct_bad;
  logic [31:0] imm_ext;
  logic [31:0] op_a;
  logic [31:0] op_b_reg;
  logic [31:0] op_b;

  assign out_valid = (state_q == CHEIO);
  assign in_ready  = !out_valid || bus.ex_ready;
  assign load      = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    alu_dec   = 4'b0000;
    funct_bad = 1'b0;
    case (bus.ALUOp)
      2'b00: alu_dec = 4'b0010;
      2'b01: alu_dec = 4'b0110;
      2'b11: alu_dec = 4'b0001;
      default: begin
        case (bus.funct)
          6'b100000: alu_dec = 4'b0010;
          6'b100010: alu_dec = 4'b0110;
          6'b100100: alu_dec = 4'b0000;
          6'b100101: alu_dec = 4'b0001;
          6'b101010: alu_dec = 4'b0111;
          6'b100111: alu_dec = 4'b1100;
          default: begin
            alu_dec   = 4'b1111;
            funct_bad = 1'b1;
          end
        endcase
      end
    endcase
  end

  // The logical-immediate class (ALUOp 11) wants an unsigned immediate.
  assign imm_ext = (bus.ALUOp == 2'b11) ? {16'h0000, bus.imediato}
                                        : {{16{bus.imediato[15]}}, bus.imediato};

`ifdef FORWARDING_EN
  logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic wb_hold_a, wb_hold_b;

  assign mem_hit_a = bus.fw_mem_valid && (bus.fw_mem_reg != 5'd0) && (bus.fw_mem_reg == bus.rs);
  assign wb_hit_a  = bus.fw_wb_valid  && (bus.fw_wb_reg  != 5'd0) && (bus.fw_wb_reg  == bus.rs);
  assign mem_hit_b = bus.fw_mem_valid && (bus.fw_mem_reg != 5'd0) && (bus.fw_mem_reg == bus.rt);
  assign wb_hit_b  = bus.fw_wb_valid  && (bus.fw_wb_reg  != 5'd0) && (bus.fw_wb_reg  == bus.rt);

  assign op_a     = mem_hit_a ? bus.fw_mem_dado : (wb_hit_a ? bus.fw_wb_dado : bus.leituraA);
  assign op_b_reg = mem_hit_b ? bus.fw_mem_dado : (wb_hit_b ? bus.fw_wb_dado : bus.leituraB);

  // A stalled instruction must still see results retiring through WB meanwhile.
  assign wb_hold_a = bus.fw_wb_valid && (bus.fw_wb_reg != 5'd0) && (bus.fw_wb_reg == rs_q);
  assign wb_hold_b = bus.fw_wb_valid && (bus.fw_wb_reg != 5'd0) && (bus.fw_wb_reg == rt_q)
                     && b_reg_q;
`else
  logic unused_fw;

  assign unused_fw = ^{bus.fw_mem_valid, bus.fw_mem_reg, bus.fw_mem_dado,
                       bus.fw_wb_valid, bus.fw_wb_reg, bus.fw_wb_dado};
  assign op_a      = bus.leituraA;
  assign op_b_reg  = bus.leituraB;
`endif

  assign op_b = bus.ALUSrc ? imm_ext : op_b_reg;

  // Flush outranks both a new load and consumption by EX.
  always_comb begin
    state_d       = state_q;
    alu_control_d = alu_control_q;
    entrada_a_d   = entrada_a_q;
    entrada_b_d   = entrada_b_q;
    reg_destino_d = reg_destino_q;
    erro_funct_d  = erro_funct_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    b_reg_d       = b_reg_q;

    if (bus.flush) begin
      state_d = VAZIO;
    end else if (load) begin
      state_d       = CHEIO;
      alu_control_d = alu_dec;
      erro_funct_d  = funct_bad;
      entrada_a_d   = op_a;
      entrada_b_d   = op_b;
      reg_destino_d = bus.RegDst ? bus.rd : bus.rt;
      rs_d          = bus.rs;
      rt_d          = bus.rt;
      b_reg_d       = !bus.ALUSrc;
    end else if (out_valid && bus.ex_ready) begin
      state_d = VAZIO;
    end
`ifdef FORWARDING_EN
    else if (out_valid) begin
      if (wb_hold_a) entrada_a_d = bus.fw_wb_dado;
      if (wb_hold_b) entrada_b_d = bus.fw_wb_dado;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= VAZIO;
      alu_control_q <= 4'b0000;
      entrada_a_q   <= 32'd0;
      entrada_b_q   <= 32'd0;
      reg_destino_q <= 5'd0;
      erro_funct_q  <= 1'b0;
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      b_reg_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_control_q <= alu_control_d;
      entrada_a_q   <= entrada_a_d;
      entrada_b_q   <= entrada_b_d;
      reg_destino_q <= reg_destino_d;
      erro_funct_q  <= erro_funct_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      b_reg_q       <= b_reg_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.ALUcontrol = alu_control_q;
  assign bus.entradaA   = entrada_a_q;
  assign bus.entradaB   = entrada_b_q;
  assign bus.regDestino = reg_destino_q;
  assign bus.erro_funct = erro_funct_q;

endmodule

// File: tb/tb_estagio_id_ex.sv
// Scoreboard bench for estagio_id_ex: directed corner cases then random traffic,
// checked against a transaction-level reference model (honours FORWARDING_EN).
module tb_estagio_id_ex;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  estagio_id_ex_if bus ();

  estagio_id_ex dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        err;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        b_reg;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;

  logic [5:0] good_functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // {erro_funct, ALUcontrol} from the opcode class and funct field.
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b11) return 5'b0_0001;
    case (f)
      6'h20:   return 5'b0_0010;
      6'h22:   return 5'b0_0110;
      6'h24:   return 5'b0_0000;
      6'h25:   return 5'b0_0001;
      6'h2A:   return 5'b0_0111;
      6'h27:   return 5'b0_1100;
      default: return 5'b1_1111;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] src, input logic [31:0] dflt);
`ifdef FORWARDING_EN
    if (bus.fw_mem_valid && src != 5'd0 && bus.fw_mem_reg == src) return bus.fw_mem_dado;
    if (bus.fw_wb_valid  && src != 5'd0 && bus.fw_wb_reg  == src) return bus.fw_wb_dado;
`endif
    return dflt;
  endfunction

  function automatic exp_t model_load();
    exp_t        e;
    logic [4:0]  ctl;
    int          imm_s;
    int unsigned imm_u;
    ctl     = decode(bus.ALUOp, bus.funct);
    imm_s   = $signed(bus.imediato);
    imm_u   = bus.imediato;
    e.alu   = ctl[3:0];
    e.err   = ctl[4];
    e.rs    = bus.rs;
    e.rt    = bus.rt;
    e.b_reg = !bus.ALUSrc;
    e.a     = pick(bus.rs, bus.leituraA);
    if (!bus.ALUSrc)            e.b = pick(bus.rt, bus.leituraB);
    else if (bus.ALUOp == 2'b11) e.b = imm_u;
    else                         e.b = imm_s;
    e.dest  = bus.RegDst ? bus.rd : bus.rt;
    return e;
  endfunction

  // Called once per cycle after the inputs for the coming edge are driven.
  task automatic applyStimulus();
    int held;
    bit accept;
    held   = sb.size();
    accept = bus.in_valid && (held == 0 || bus.ex_ready) && !bus.flush;
`ifdef FORWARDING_EN
    if (held > 0 && !bus.ex_ready && !bus.flush && bus.fw_wb_valid && bus.fw_wb_reg != 5'd0) begin
      exp_t tmp;
      tmp = sb[0];
      if (bus.fw_wb_reg == tmp.rs) tmp.a = bus.fw_wb_dado;
      if (tmp.b_reg && bus.fw_wb_reg == tmp.rt) tmp.b = bus.fw_wb_dado;
      sb[0] = tmp;
    end
`endif
    if (accept) sb.push_back(model_load());
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.ex_ready     = 1'b1;
    bus.flush        = 1'b0;
    bus.ALUOp        = 2'b00;
    bus.funct        = 6'h00;
    bus.ALUSrc       = 1'b0;
    bus.RegDst       = 1'b0;
    bus.leituraA     = 32'd0;
    bus.leituraB     = 32'd0;
    bus.imediato     = 16'd0;
    bus.rs           = 5'd0;
    bus.rt           = 5'd0;
    bus.rd           = 5'd0;
    bus.fw_mem_valid = 1'b0;
    bus.fw_mem_reg   = 5'd0;
    bus.fw_mem_dado  = 32'd0;
    bus.fw_wb_valid  = 1'b0;
    bus.fw_wb_reg    = 5'd0;
    bus.fw_wb_dado   = 32'd0;
  endtask

  task automatic randomFields();
    bus.in_valid     = ($urandom_range(0, 9) < 7);
    bus.ex_ready     = ($urandom_range(0, 9) < 6);
    bus.flush        = ($urandom_range(0, 19) == 0);
    bus.ALUOp        = 2'($urandom);
    bus.funct        = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                                                   : good_functs[$urandom_range(0, 5)];
    bus.ALUSrc       = 1'($urandom);
    bus.RegDst       = 1'($urandom);
    bus.leituraA     = $urandom;
    bus.leituraB     = $urandom;
    bus.imediato     = 16'($urandom);
    bus.rs           = 5'($urandom_range(0, 7));
    bus.rt           = 5'($urandom_range(0, 7));
    bus.rd           = 5'($urandom);
    bus.fw_mem_valid = 1'($urandom);
    bus.fw_mem_reg   = 5'($urandom_range(0, 7));
    bus.fw_mem_dado  = $urandom;
    bus.fw_wb_valid  = 1'($urandom);
    bus.fw_wb_reg    = 5'($urandom_range(0, 7));
    bus.fw_wb_dado   = $urandom;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out_valid"},  bus.out_valid,  32'd0);
    checkOutput({tag, "_ALUcontrol"}, bus.ALUcontrol, 32'd0);
    checkOutput({tag, "_entradaA"},   bus.entradaA,   32'd0);
    checkOutput({tag, "_entradaB"},   bus.entradaB,   32'd0);
    checkOutput({tag, "_regDestino"}, bus.regDestino, 32'd0);
    checkOutput({tag, "_erro_funct"}, bus.erro_funct, 32'd0);
  endtask

  // Monitor: outputs compared on the falling edge, consumption/flush resolved
  // just after the stimulus for the next rising edge is on the bus.
  initial begin
    int   held;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) continue;
      held = sb.size();
      checkOutput("out_valid", bus.out_valid, (held > 0) ? 32'd1 : 32'd0);
      cur = (held > 0) ? sb[0] : last;
      checkOutput("ALUcontrol", bus.ALUcontrol, cur.alu);
      checkOutput("entradaA",   bus.entradaA,   cur.a);
      checkOutput("entradaB",   bus.entradaB,   cur.b);
      checkOutput("regDestino", bus.regDestino, cur.dest);
      checkOutput("erro_funct", bus.erro_funct, cur.err);
      last = cur;
      #2;
      checkOutput("in_ready", bus.in_ready, (held == 0 || bus.ex_ready) ? 32'd1 : 32'd0);
      if (held > 0 && (bus.ex_ready || bus.flush)) void'(sb.pop_front());
    end
  end

  initial begin
    #500000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    last  = '{default: 0};
    rst_n = 1'b0;
    idle();
    #1;
    checkAllZero("reset");
    checkOutput("reset_in_ready", bus.in_ready, 32'd1);

    // Release reset and load on the very first edge afterwards.
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.funct = 6'b100010;
    bus.leituraA = 32'd9; bus.leituraB = 32'd4;
    bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.RegDst = 1'b1;
    applyStimulus();

    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b00; bus.ALUSrc = 1'b1; bus.imediato = 16'hFFFC;
    applyStimulus();

    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b11; bus.ALUSrc = 1'b1; bus.imediato = 16'hFFFC;
    bus.rt = 5'd9;
    applyStimulus();

    // MEM beats WB on rs=5; then register 0 never forwards.
    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b00; bus.rs = 5'd5; bus.leituraA = 32'h99;
    bus.fw_mem_valid = 1'b1; bus.fw_mem_reg = 5'd5; bus.fw_mem_dado = 32'h11;
    bus.fw_wb_valid  = 1'b1; bus.fw_wb_reg  = 5'd5; bus.fw_wb_dado  = 32'h22;
    applyStimulus();

    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b00; bus.rs = 5'd0; bus.rt = 5'd0;
    bus.leituraA = 32'h5A5A; bus.leituraB = 32'h3C3C;
    bus.fw_mem_valid = 1'b1; bus.fw_mem_reg = 5'd0; bus.fw_mem_dado = 32'h11;
    bus.fw_wb_valid  = 1'b1; bus.fw_wb_reg  = 5'd0; bus.fw_wb_dado  = 32'h22;
    applyStimulus();

    // Load rt=7, then stall three cycles with WB retiring r7 on the first.
    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.funct = 6'h20;
    bus.rs = 5'd6; bus.rt = 5'd7; bus.leituraA = 32'h1; bus.leituraB = 32'h1234;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      nextCycle(); idle();
      bus.in_valid = 1'b1; bus.ex_ready = 1'b0; bus.ALUOp = 2'b01;
      bus.leituraA = 32'hDEAD0000 + i; bus.rs = 5'd3; bus.rt = 5'd4;
      if (i == 0) begin
        bus.fw_wb_valid = 1'b1; bus.fw_wb_reg = 5'd7; bus.fw_wb_dado = 32'hAB;
      end
      applyStimulus();
    end

    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.funct = 6'b000000; bus.rd = 5'd17;
    bus.RegDst = 1'b1;
    applyStimulus();

    // Flush drops both the held and the offered instruction.
    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.ex_ready = 1'b0; bus.leituraA = 32'h77;
    applyStimulus();
    nextCycle(); idle();
    applyStimulus();

    // Asynchronous reset in the middle of a cycle while an instruction is held.
    nextCycle(); idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.funct = 6'h2A;
    bus.leituraA = 32'hCAFE; bus.leituraB = 32'hBEEF; bus.rd = 5'd12; bus.RegDst = 1'b1;
    applyStimulus();
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.ex_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    sb.delete();
    last = '{default: 0};
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.funct = 6'h27;
    bus.leituraA = 32'h0F0F; bus.leituraB = 32'hF0F0; bus.rt = 5'd21;
    applyStimulus();

    for (int n = 0; n < 1500; n++) begin
      nextCycle();
      randomFields();
      applyStimulus();
    end

    for (int n = 0; n < 4; n++) begin
      nextCycle();
      idle();
      applyStimulus();
    end
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/estagio_id_ex.md
ESTAGIO_ID_EX -- requirements
Module: estagio_id_ex

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid in 1 decode offers instr; in_ready out 1 stage can accept; ex_ready in 1 EX/MEM consumes this cycle; flush in 1 discard.
REQ-004 SHALL have: ALUOp in 2; funct in 6; ALUSrc in 1 (1 = B from imediato); RegDst in 1 (1 = rd else rt).
REQ-005 SHALL have: leituraA, leituraB in 32 register-file reads; imediato in 16; rs, rt, rd in 5.
REQ-006 SHALL have: fw_mem_valid in 1, fw_mem_reg in 5, fw_mem_dado in 32; fw_wb_valid in 1, fw_wb_reg in 5, fw_wb_dado in 32.
REQ-007 SHALL have: out_valid out 1; ALUcontrol out 4; entradaA, entradaB out 32 (drive ALU directly); regDestino out 5; erro_funct out 1.

Function
REQ-008 SHALL be a one-entry pipeline register, states VAZIO (out_valid=0) and CHEIO (out_valid=1); all outputs registered.
REQ-009 SHALL drive in_ready = !out_valid | ex_ready, combinationally, independent of in_valid.
REQ-010 SHALL load on edge when in_valid & in_ready & !flush; load -> CHEIO, outputs update next cycle (latency 1).
REQ-011 SHALL go CHEIO->VAZIO when ex_ready & !(in_valid) & !flush; CHEIO with ex_ready & in_valid loads back-to-back, no bubble.
REQ-012 SHALL hold all outputs bit-stable while CHEIO & !ex_ready, except REQ-019.
REQ-013 SHALL on flush=1 go VAZIO next edge, dropping held and offered instr; flush beats load and ex_ready.
REQ-014 SHALL map ALUcontrol: ALUOp 00 -> 0010; 01 -> 0110; 11 -> 0001; 10 -> by funct.
REQ-015 SHALL map funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
REQ-016 SHALL for ALUOp=10 with other funct register ALUcontrol=1111 and erro_funct=1; erro_funct=0 for every other load.
REQ-017 SHALL form B immediate as sign-extended imediato, except ALUOp=11 zero-extends; ALUSrc=0 uses register operand.
REQ-018 SHALL select A (from rs) and register B (from rt) at load: MEM match, else WB match, else leituraA/B; match = valid & reg==src & reg!=0.
REQ-019 SHALL while CHEIO & !ex_ready, on fw_wb_valid & fw_wb_reg!=0 matching stored rs/rt, overwrite entradaA / register-sourced entradaB with fw_wb_dado next edge.
REQ-020 SHALL store rs, rt internally for REQ-019; regDestino = RegDst ? rd : rt.
REQ-021 SHALL in VAZIO keep data outputs at last value; only out_valid qualifies them.

Reset
REQ-022 SHALL on rst_n=0 immediately force VAZIO: out_valid 0, ALUcontrol 0000, entradaA/B 0, regDestino 0, erro_funct 0, stored rs/rt 0.
REQ-023 SHALL discard in-flight instr on reset mid-operation; first load possible on first edge after rst_n rises.

Configuration
REQ-024 SHALL with FORWARDING_EN defined implement REQ-018 and REQ-019.
REQ-025 SHALL without FORWARDING_EN take operands only from leituraA/B/imediato, ignore all fw_* inputs, omit REQ-019; all else identical.

Verification
REQ-026 SHALL cover: ALUOp=10, funct=100010, leituraA=9, leituraB=4, ex_ready=1 -> next cycle out_valid=1, ALUcontrol=0110, A=9, B=4.
REQ-027 SHALL cover: ALUOp=00, ALUSrc=1, imediato=FFFC -> B=FFFFFFFC; ALUOp=11, imediato=FFFC -> B=0000FFFC, ALUcontrol=0001.
REQ-028 SHALL cover: rs=5, fw_mem 5/0x11, fw_wb 5/0x22 -> A=0x11; rs=0 with both matching reg 0 -> A=leituraA (FORWARDING_EN).
REQ-029 SHALL cover: CHEIO, ex_ready=0 three cycles, in_valid=1 -> in_ready=0, outputs stable; fw_wb 7/0xAB with stored rt=7, ALUSrc=0 -> B=0xAB.
REQ-030 SHALL cover: funct=000000 with ALUOp=10 -> ALUcontrol=1111, erro_funct=1; flush with in_valid=1 -> out_valid=0 next cycle.
REQ-031 SHALL cover: rst_n low mid-cycle while CHEIO -> out_valid=0 and all outputs 0 before next clk edge.
